// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_fifo_if : byte write channel (valid/ready) into the UART TX FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_fifo : UART transmitter with TX FIFO, programmable frame and break
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter  int FIFO_DEPTH = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             resetn,
  uart_tx_fifo_if.slave         tx_if,
  input  wire logic [15:0]      cfg_div,
  input  wire logic [3:0]       cfg_data_bits,
  input  wire logic [1:0]       cfg_parity,
  input  wire logic             cfg_stop2,
  input  wire logic             tx_break,
  output logic                  uart_txd,
  output logic                  busy,
  output logic [LVL_W-1:0]      fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d, cnt_inc;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  nbits_q, nbits_d;
  logic [1:0]  par_q, par_d;
  logic        stop2_q, stop2_d, stop_q, stop_d, rel_q, rel_d, txd_q, txd_d;

  logic       push, pop, empty, bit_end, par_en, par_bit;
  logic [3:0] nbits_clamp;
  logic [7:0] mask;

  assign tx_if.tx_ready = (level_q < LVL_W'(FIFO_DEPTH));
  assign push           = tx_if.tx_valid && tx_if.tx_ready;
  assign empty          = (level_q == '0);
  assign fifo_level     = level_q;
  assign uart_txd       = txd_q;
  assign busy           = (state_q != IDLE) || !empty;

  assign nbits_clamp = (cfg_data_bits < 4'd5) ? 4'd5 :
                       (cfg_data_bits > 4'd8) ? 4'd8 : cfg_data_bits;
  assign mask        = 8'hFF >> (4'd8 - nbits_clamp);
  // Data is stored pre-masked, so the parity is a plain reduction.
  assign par_en      = par_q[0] ^ par_q[1];
  assign par_bit     = (^data_q) ^ par_q[1];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_if.tx_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    data_d  = data_q;
    nbits_d = nbits_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    stop_d  = stop_q;
    rel_d   = rel_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    bit_end = (cnt_q == div_q);
    cnt_inc = bit_end ? 16'd0 : cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_break) begin
          state_d = BREAK;
          txd_d   = 1'b0;
          rel_d   = 1'b0;
          div_d   = cfg_div;
        end else if (!empty) begin
          pop = 1'b1;
        end
      end
      START: begin
        cnt_d = cnt_inc;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = data_q[0];
        end
      end
      DATA: begin
        cnt_d = cnt_inc;
        if (bit_end) begin
          if ({1'b0, bit_q} == nbits_q - 4'd1) begin
            state_d = par_en ? PARITY : STOP;
            txd_d   = par_en ? par_bit : 1'b1;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = data_q[bit_q + 3'd1];
          end
        end
      end
      PARITY: begin
        cnt_d = cnt_inc;
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        cnt_d = cnt_inc;
        if (bit_end) begin
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
          end else if (tx_break) begin
            state_d = BREAK;
            txd_d   = 1'b0;
            rel_d   = 1'b0;
            div_d   = cfg_div;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        if (!rel_q) begin
          cnt_d = '0;
          if (!tx_break) begin
            rel_d = 1'b1;
            txd_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          if (bit_end) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every frame start (from IDLE or back-to-back from STOP) lands here.
    if (pop) begin
      state_d = START;
      txd_d   = 1'b0;
      cnt_d   = '0;
      data_d  = mem_q[rd_ptr_q] & mask;
      nbits_d = nbits_clamp;
      par_d   = cfg_parity;
      stop2_d = cfg_stop2;
      div_d   = cfg_div;
    end
  end

  assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      nbits_q  <= 4'd8;
      par_q    <= '0;
      stop2_q  <= 1'b0;
      stop_q   <= 1'b0;
      rel_q    <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q  <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      nbits_q  <= nbits_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      stop_q   <= stop_d;
      rel_q    <= rel_d;
      txd_q    <= txd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo (depth 4)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        tx_break;
  logic        uart_txd;
  logic        busy;
  logic [2:0]  fifo_level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .tx_if         (bus.slave),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_break      (tx_break),
    .uart_txd      (uart_txd),
    .busy          (busy),
    .fifo_level    (fifo_level)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    int n = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    while (!bus.tx_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check_eq("push_timeout", 1, 0);
    tick();
    bus.tx_valid = 1'b0;
  endtask

  // Checks a whole frame bit by bit, one comparison per clock cycle.
  task automatic expect_frame(input logic [7:0] d, input int nb, input logic [1:0] par,
                              input logic s2, input int div, input bit immediate,
                              input string tag);
    logic exp_bits [12];
    int   nexp = 0;
    logic x = 1'b0;
    int   n = 0;
    exp_bits[nexp++] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      exp_bits[nexp++] = d[i];
      x ^= d[i];
    end
    if (par == 2'b01) exp_bits[nexp++] = x;
    if (par == 2'b10) exp_bits[nexp++] = ~x;
    exp_bits[nexp++] = 1'b1;
    if (s2) exp_bits[nexp++] = 1'b1;

    if (immediate) begin
      tick();
    end else begin
      while (uart_txd !== 1'b0 && n < 3000) begin
        tick();
        n++;
      end
      if (n >= 3000) begin
        check_eq({tag, "_start_timeout"}, 1, 0);
        return;
      end
    end
    for (int b = 0; b < nexp; b++) begin
      for (int c = 0; c <= div; c++) begin
        if (b != 0 || c != 0) tick();
        check_eq($sformatf("%s_bit%0d", tag, b), uart_txd, exp_bits[b]);
      end
    end
  endtask

  initial begin
    logic [7:0] q3 [6];
    int lows;
    bit saw_full;

    q3[0] = 8'h11; q3[1] = 8'h22; q3[2] = 8'h33;
    q3[3] = 8'h44; q3[4] = 8'h55; q3[5] = 8'h66;

    resetn        = 1'b0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    cfg_div       = 16'd3;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    tx_break      = 1'b0;
    repeat (3) tick();
    check_eq("rst_txd", uart_txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", bus.tx_ready, 1);
    check_eq("rst_level", fifo_level, 0);
    resetn = 1'b1;
    tick();

    // 8N1, 4 cycles per bit
    push_byte(8'hA5);
    expect_frame(8'hA5, 8, 2'b00, 1'b0, 3, 1'b0, "t1");
    tick();
    check_eq("t1_busy_low", busy, 0);
    check_eq("t1_level", fifo_level, 0);
    check_eq("t1_idle_txd", uart_txd, 1);

    // 7E2 then 5O2, 2 cycles per bit
    cfg_div = 16'd1; cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    push_byte(8'h41);
    expect_frame(8'h41, 7, 2'b01, 1'b1, 1, 1'b0, "t2a");
    cfg_data_bits = 4'd5; cfg_parity = 2'b10;
    push_byte(8'h1F);
    expect_frame(8'h1F, 5, 2'b10, 1'b1, 1, 1'b0, "t2b");
    tick();

    // Six back-to-back bytes through a 4-deep FIFO
    cfg_div = 16'd15; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    saw_full = 1'b0;
    fork
      begin
        int i = 0;
        int n = 0;
        logic rdy;
        bus.tx_valid = 1'b1;
        bus.tx_data  = q3[0];
        while (i < 6 && n < 3000) begin
          rdy = bus.tx_ready;
          tick();
          n++;
          if (fifo_level == 3'd4) begin
            saw_full = 1'b1;
            check_eq("t3_ready_full", bus.tx_ready, 0);
          end
          if (rdy) begin
            i++;
            if (i < 6) bus.tx_data = q3[i];
            else       bus.tx_valid = 1'b0;
          end
        end
        bus.tx_valid = 1'b0;
        check_eq("t3_all_pushed", i, 6);
      end
      begin
        expect_frame(q3[0], 8, 2'b00, 1'b0, 15, 1'b0, "t3f0");
        for (int k = 1; k < 6; k++)
          expect_frame(q3[k], 8, 2'b00, 1'b0, 15, 1'b1, $sformatf("t3f%0d", k));
      end
    join
    check_eq("t3_saw_full", saw_full, 1);
    tick();
    check_eq("t3_busy_low", busy, 0);

    // Divisor change mid-frame only affects the next frame
    cfg_div = 16'd3;
    push_byte(8'h3C);
    push_byte(8'h96);
    fork
      begin
        expect_frame(8'h3C, 8, 2'b00, 1'b0, 3, 1'b0, "t4a");
        expect_frame(8'h96, 8, 2'b00, 1'b0, 7, 1'b1, "t4b");
      end
      begin
        repeat (12) tick();
        cfg_div = 16'd7;
      end
    join
    tick();
    cfg_div = 16'd3;

    // Break requested mid-frame is deferred until the frame ends
    push_byte(8'h55);
    lows = 0;
    fork
      begin
        int n = 0;
        expect_frame(8'h55, 8, 2'b00, 1'b0, 3, 1'b0, "t5a");
        tick();
        while (uart_txd === 1'b0 && n < 200) begin
          lows++;
          tick();
          n++;
        end
      end
      begin
        repeat (8) tick();
        tx_break = 1'b1;
        push_byte(8'h33);
        repeat (49) tick();
        tx_break = 1'b0;
      end
    join
    check_eq("t5_break_long", (lows >= 10), 1);
    check_eq("t5_released", tx_break, 0);
    for (int c = 0; c < 4; c++) begin
      if (c != 0) tick();
      check_eq("t5_release_high", uart_txd, 1);
    end
    check_eq("t5_still_queued", fifo_level, 1);
    expect_frame(8'h33, 8, 2'b00, 1'b0, 3, 1'b0, "t5b");
    tick();

    // Reset in the middle of DATA with three bytes queued
    push_byte(8'hC3);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    repeat (8) tick();
    check_eq("t6_queued", fifo_level, 3);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_eq("t6_txd", uart_txd, 1);
    check_eq("t6_level", fifo_level, 0);
    check_eq("t6_ready", bus.tx_ready, 1);
    check_eq("t6_busy", busy, 0);
    lows = 0;
    repeat (100) begin
      tick();
      if (uart_txd !== 1'b1) lows++;
    end
    check_eq("t6_no_start", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
